// File: rtl/sid_pkg.sv
// Shared constants and types for the SID voice register interface.
package sid_pkg;

  localparam int SID_ADDR_W     = 3;
  localparam int SID_VOICE_W    = 2;
  localparam int SID_NUM_VOICES = 3;

  // Per-voice register map
  localparam logic [SID_ADDR_W-1:0] REG_FREQ_LO  = 3'd0;
  localparam logic [SID_ADDR_W-1:0] REG_FREQ_HI  = 3'd1;
  localparam logic [SID_ADDR_W-1:0] REG_PW       = 3'd2;
  localparam logic [SID_ADDR_W-1:0] REG_ATTACK   = 3'd4;
  localparam logic [SID_ADDR_W-1:0] REG_SUSTAIN  = 3'd5;
  localparam logic [SID_ADDR_W-1:0] REG_WAVEFORM = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sid_sync.sv
// Multi-flop bit synchronizer for one asynchronous input, with a selectable reset value.
module sid_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sid_spi_regif.sv
// SPI mode-0 slave to single-cycle register write bridge for the SID voice banks.
// Define SID_SPI_AUTOINC_EN to let burst data bytes write successive addresses.
module sid_spi_regif
  import sid_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = SID_ADDR_W,
  parameter int VOICE_W     = SID_VOICE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               wr_stb,
  output logic [VOICE_W-1:0] wr_voice,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  output logic               frame_err,
  output logic               busy
);

`ifdef SID_SPI_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  logic sclkSync, csSync, mosiSync;

  // Chip select idles high so reset never looks like the start of a frame
  sid_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSclk (
    .clk(clk), .rst(rst), .d_i(spi_sclk), .q_o(sclkSync));
  sid_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncCs (
    .clk(clk), .rst(rst), .d_i(spi_cs_n), .q_o(csSync));
  sid_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncMosi (
    .clk(clk), .rst(rst), .d_i(spi_mosi), .q_o(mosiSync));

  spi_state_e         state_q;
  logic               sclkDly_q, csDly_q;
  logic [2:0]         bitCnt_q;
  logic [7:0]         shift_q;
  logic               hdrWr_q, firstData_q;
  logic [VOICE_W-1:0] hdrVoice_q;
  logic [ADDR_W-1:0]  hdrAddr_q;
  logic               wrStb_q, frameErr_q;
  logic [VOICE_W-1:0] wrVoice_q;
  logic [ADDR_W-1:0]  wrAddr_q;
  logic [7:0]         wrData_q;

  logic       sclkRise, csFall, csRise, byteDone, voiceBad;
  logic [7:0] shiftNext;

  assign sclkRise  = sclkSync & ~sclkDly_q;
  assign csFall    = ~csSync & csDly_q;
  assign csRise    = csSync & ~csDly_q;
  assign shiftNext = {shift_q[6:0], mosiSync};
  assign byteDone  = (state_q != ST_IDLE) && sclkRise && (bitCnt_q == 3'd7);
  assign voiceBad  = (int'(hdrVoice_q) >= SID_NUM_VOICES);

  // A byte finishing in the same cycle as cs_n rising is processed before returning to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclkDly_q   <= 1'b0;
      csDly_q     <= 1'b1;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      hdrWr_q     <= 1'b0;
      firstData_q <= 1'b0;
      hdrVoice_q  <= '0;
      hdrAddr_q   <= '0;
      wrStb_q     <= 1'b0;
      frameErr_q  <= 1'b0;
      wrVoice_q   <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= 8'd0;
    end else begin
      sclkDly_q  <= sclkSync;
      csDly_q    <= csSync;
      wrStb_q    <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (csFall) begin
            state_q  <= ST_HDR;
            bitCnt_q <= 3'd0;
            shift_q  <= 8'd0;
          end
        end
        default: begin
          if (sclkRise) begin
            shift_q  <= shiftNext;
            bitCnt_q <= bitCnt_q + 3'd1;
          end
          if (byteDone) begin
            if (state_q == ST_HDR) begin
              hdrWr_q     <= shiftNext[7];
              hdrVoice_q  <= shiftNext[ADDR_W +: VOICE_W];
              hdrAddr_q   <= shiftNext[ADDR_W-1:0];
              firstData_q <= 1'b1;
              state_q     <= ST_DATA;
            end else begin
              firstData_q <= 1'b0;
              if (voiceBad) begin
                if (firstData_q) frameErr_q <= 1'b1;
              end else if (hdrWr_q && (AUTOINC || firstData_q)) begin
                wrStb_q   <= 1'b1;
                wrVoice_q <= hdrVoice_q;
                wrAddr_q  <= hdrAddr_q;
                wrData_q  <= shiftNext;
                hdrAddr_q <= hdrAddr_q + 1'b1;
              end
            end
          end
          if (csRise) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= 3'd0;
            if (!byteDone && bitCnt_q != 3'd0) frameErr_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign wr_stb    = wrStb_q;
  assign wr_voice  = wrVoice_q;
  assign wr_addr   = wrAddr_q;
  assign wr_data   = wrData_q;
  assign frame_err = frameErr_q;
  assign busy      = ~csSync;

endmodule

// File: tb/tb_sid_spi_regif.sv
// Directed self-checking bench for sid_spi_regif; honours SID_SPI_AUTOINC_EN like the RTL.
module tb_sid_spi_regif;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       wr_stb;
  logic [1:0] wr_voice;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       busy;

  int assertCount = 0;
  int failCount   = 0;
  int cycCnt      = 0;
  int lastRiseCyc = 0;
  int errCycles   = 0;

  logic [1:0] stbVoice[$];
  logic [2:0] stbAddr[$];
  logic [7:0] stbData[$];
  int         stbCyc[$];

  sid_spi_regif dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .wr_stb(wr_stb), .wr_voice(wr_voice), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Record every strobe and every cycle of frame_err, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_stb) begin
      stbVoice.push_back(wr_voice);
      stbAddr.push_back(wr_addr);
      stbData.push_back(wr_data);
      stbCyc.push_back(cycCnt);
    end
    if (frame_err) errCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLog();
    stbVoice.delete();
    stbAddr.delete();
    stbData.delete();
    stbCyc.delete();
    errCycles = 0;
  endtask

  task automatic csLow();
    @(negedge clk);
    spi_cs_n = 1'b0;
    waitClocks(6);
  endtask

  task automatic csHigh();
    waitClocks(4);
    spi_cs_n = 1'b1;
    waitClocks(10);
  endtask

  // Sends the top nbits of b, MSB first, with an 8-clock sclk period
  task automatic applyStimulus(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      waitClocks(4);
      spi_sclk = 1'b1;
      lastRiseCyc = cycCnt;
      waitClocks(4);
      spi_sclk = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    waitClocks(4);
    checkOutput("reset wr_stb", 32'(wr_stb), 0);
    checkOutput("reset frame_err", 32'(frame_err), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset wr_data", 32'(wr_data), 0);
    @(negedge clk);
    rst = 1'b0;
    waitClocks(4);

    // 1: voice0 addr2 <= 0x5A
    clearLog();
    csLow();
    applyStimulus(8'h82, 8);
    checkOutput("t1 busy in frame", 32'(busy), 1);
    applyStimulus(8'h5A, 8);
    csHigh();
    checkOutput("t1 stb count", stbData.size(), 1);
    checkOutput("t1 voice", 32'(stbVoice[0]), 0);
    checkOutput("t1 addr", 32'(stbAddr[0]), 2);
    checkOutput("t1 data", 32'(stbData[0]), 32'h5A);
    checkOutput("t1 frame_err", errCycles, 0);
    checkOutput("t1 busy after", 32'(busy), 0);

    // 2: voice2 addr1 <= 0xC3; two sync flops plus the output register give 3 clocks
    clearLog();
    csLow();
    applyStimulus(8'h91, 8);
    applyStimulus(8'hC3, 8);
    csHigh();
    checkOutput("t2 stb count", stbData.size(), 1);
    checkOutput("t2 voice", 32'(stbVoice[0]), 2);
    checkOutput("t2 addr", 32'(stbAddr[0]), 1);
    checkOutput("t2 data", 32'(stbData[0]), 32'hC3);
    checkOutput("t2 latency", 32'(stbCyc[0] - lastRiseCyc), 3);

    // 3: voice 3 is invalid
    clearLog();
    csLow();
    applyStimulus(8'h98, 8);
    applyStimulus(8'h11, 8);
    csHigh();
    checkOutput("t3 stb count", stbData.size(), 0);
    checkOutput("t3 frame_err cycles", errCycles, 1);
    checkOutput("t3 wr_data held", 32'(wr_data), 32'hC3);
    checkOutput("t3 wr_voice held", 32'(wr_voice), 2);

    // 4: abort after 12 bits, then a clean frame
    clearLog();
    csLow();
    applyStimulus(8'h82, 8);
    applyStimulus(8'hF0, 4);
    csHigh();
    checkOutput("t4 stb count", stbData.size(), 0);
    checkOutput("t4 frame_err cycles", errCycles, 1);
    checkOutput("t4 busy after", 32'(busy), 0);
    clearLog();
    csLow();
    applyStimulus(8'h85, 8);
    applyStimulus(8'h77, 8);
    csHigh();
    checkOutput("t4 clean stb count", stbData.size(), 1);
    checkOutput("t4 clean addr", 32'(stbAddr[0]), 5);
    checkOutput("t4 clean data", 32'(stbData[0]), 32'h77);
    checkOutput("t4 clean frame_err", errCycles, 0);

    // 5: burst starting at addr6
    clearLog();
    csLow();
    applyStimulus(8'h86, 8);
    applyStimulus(8'h01, 8);
    applyStimulus(8'h02, 8);
    applyStimulus(8'h03, 8);
    csHigh();
`ifdef SID_SPI_AUTOINC_EN
    checkOutput("t5 stb count", stbData.size(), 3);
    checkOutput("t5 addr0", 32'(stbAddr[0]), 6);
    checkOutput("t5 data0", 32'(stbData[0]), 32'h01);
    checkOutput("t5 addr1", 32'(stbAddr[1]), 7);
    checkOutput("t5 data1", 32'(stbData[1]), 32'h02);
    checkOutput("t5 addr2 wrap", 32'(stbAddr[2]), 0);
    checkOutput("t5 data2", 32'(stbData[2]), 32'h03);
    checkOutput("t5 voice2", 32'(stbVoice[2]), 0);
`else
    checkOutput("t5 stb count", stbData.size(), 1);
    checkOutput("t5 addr0", 32'(stbAddr[0]), 6);
    checkOutput("t5 data0", 32'(stbData[0]), 32'h01);
    checkOutput("t5 wr_data held", 32'(wr_data), 32'h01);
`endif
    checkOutput("t5 frame_err", errCycles, 0);

    // 6: reset in the middle of a data byte, then a wr=0 frame
    clearLog();
    csLow();
    applyStimulus(8'h82, 8);
    applyStimulus(8'hAA, 4);
    @(negedge clk);
    rst = 1'b1;
    waitClocks(2);
    checkOutput("t6 rst wr_data", 32'(wr_data), 0);
    checkOutput("t6 rst wr_addr", 32'(wr_addr), 0);
    checkOutput("t6 rst busy", 32'(busy), 0);
    checkOutput("t6 rst wr_stb", 32'(wr_stb), 0);
    spi_cs_n = 1'b1;
    waitClocks(4);
    rst = 1'b0;
    waitClocks(4);
    clearLog();
    csLow();
    applyStimulus(8'h00, 8);
    applyStimulus(8'hFF, 8);
    csHigh();
    checkOutput("t6 stb count", stbData.size(), 0);
    checkOutput("t6 frame_err", errCycles, 0);
    checkOutput("t6 wr_data held", 32'(wr_data), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
